// File: rtl/op_fwd_mux.sv
// Operand forwarding mux: picks the youngest matching producer, else the register-file value or zero.
// Latency 1 cycle on a hit, parks in WAIT while the winner is busy; holds its output while out_ready is low.
module op_fwd_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int TAGW  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_cmd,
  input  logic [TAGW-1:0]             in_tag,
  input  logic [WIDTH-1:0]            in_default,
  input  logic [NSRC-1:0]             src_valid,
  input  logic [NSRC-1:0]             src_busy,
  input  logic [NSRC*TAGW-1:0]        src_tag,
  input  logic [NSRC*WIDTH-1:0]       src_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(NSRC+1)-1:0]   out_src,
  output logic [15:0]                 stall_count
);

  localparam int SRCW = $clog2(NSRC+1);
  localparam logic [SRCW-1:0] SRC_NONE = SRCW'(NSRC);
  localparam logic [1:0] CMD_ZERO = 2'd0;
  localparam logic [1:0] CMD_FWD  = 2'd2;

  typedef enum logic [1:0] {EMPTY, WAIT, FULL} state_t;

  state_t            state, state_nxt;
  logic [1:0]        lat_cmd;
  logic [TAGW-1:0]   lat_tag;
  logic [WIDTH-1:0]  lat_dflt;

  logic [1:0]        req_cmd;
  logic [TAGW-1:0]   req_tag;
  logic [WIDTH-1:0]  req_dflt;

  logic              res_pend;
  logic              res_found;
  logic [WIDTH-1:0]  res_data;
  logic [SRCW-1:0]   res_src;

  logic              load_out;
  logic              load_lat;
  logic              stall_inc;

  // A parked request is re-resolved from its latched copy against the live sources.
  always_comb begin
    if (state == WAIT) begin
      req_cmd  = lat_cmd;
      req_tag  = lat_tag;
      req_dflt = lat_dflt;
    end else begin
      req_cmd  = in_cmd;
      req_tag  = in_tag;
      req_dflt = in_default;
    end
  end

  always_comb begin
    res_pend  = 1'b0;
    res_found = 1'b0;
    res_data  = req_dflt;
    res_src   = SRC_NONE;
    if (req_cmd == CMD_ZERO || (req_cmd == CMD_FWD && req_tag == '0)) begin
      res_data = '0;
    end else if (req_cmd == CMD_FWD) begin
      // Lowest index wins; valid beats busy at the same index.
      for (int i = 0; i < NSRC; i++) begin
        if (!res_found && src_tag[i*TAGW +: TAGW] == req_tag && (src_valid[i] || src_busy[i])) begin
          res_found = 1'b1;
          if (src_valid[i]) begin
            res_data = src_data[i*WIDTH +: WIDTH];
            res_src  = SRCW'(i);
          end else begin
            res_pend = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_out  = 1'b0;
    load_lat  = 1'b0;
    stall_inc = 1'b0;
    if (rst) begin
      state_nxt = EMPTY;
    end else if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_nxt = res_pend ? WAIT : FULL;
            load_out  = !res_pend;
            load_lat  = res_pend;
          end
        end
        WAIT: begin
          stall_inc = 1'b1;
          if (!res_pend) begin
            state_nxt = FULL;
            load_out  = 1'b1;
          end
        end
        FULL: begin
          in_ready = out_ready;
          if (out_ready) begin
            if (in_valid) begin
              state_nxt = res_pend ? WAIT : FULL;
              load_out  = !res_pend;
              load_lat  = res_pend;
            end else begin
              state_nxt = EMPTY;
            end
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      out_data    <= '0;
      out_src     <= SRC_NONE;
      stall_count <= '0;
      lat_cmd     <= '0;
      lat_tag     <= '0;
      lat_dflt    <= '0;
    end else begin
      state <= state_nxt;
      if (load_out) begin
        out_data <= res_data;
        out_src  <= res_src;
      end
      if (load_lat) begin
        lat_cmd  <= in_cmd;
        lat_tag  <= in_tag;
        lat_dflt <= in_default;
      end
      if (stall_inc && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_op_fwd_mux.sv
// Randomized and directed checks of op_fwd_mux against a request-level reference model.
module tb_op_fwd_mux;
  localparam int WIDTH = 32;
  localparam int NSRC  = 4;
  localparam int TAGW  = 5;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]        in_cmd;
  logic [TAGW-1:0]   in_tag;
  logic [WIDTH-1:0]  in_default, out_data;
  logic [NSRC-1:0]   src_valid, src_busy;
  logic [NSRC*TAGW-1:0]  src_tag;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [2:0]        out_src;
  logic [15:0]       stall_count;

  int total = 0;
  int bad   = 0;

  // Reference model: what the consumer should see, and the request still owed.
  bit         m_full, m_wait;
  logic [31:0] m_data;
  logic [2:0]  m_src;
  int          m_stall;
  logic [1:0]  l_cmd;
  logic [4:0]  l_tag;
  logic [31:0] l_dflt;
  logic        seen_rdy, exp_rdy;

  always #5 clk = ~clk;

  op_fwd_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_tag(in_tag), .in_default(in_default),
    .src_valid(src_valid), .src_busy(src_busy), .src_tag(src_tag), .src_data(src_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .stall_count(stall_count)
  );

  function automatic void ref_resolve(input logic [1:0] cmd, input logic [4:0] tag,
                                      input logic [31:0] dflt, output bit pend,
                                      output logic [31:0] d, output logic [2:0] s);
    pend = 0;
    d = dflt;
    s = 3'd4;
    if (cmd == 2'd0 || (cmd == 2'd2 && tag == 5'd0)) begin
      d = 32'd0;
      return;
    end
    if (cmd != 2'd2) return;
    for (int i = 0; i < NSRC; i++) begin
      if (src_tag[i*TAGW +: TAGW] == tag && (src_valid[i] || src_busy[i])) begin
        if (src_valid[i]) begin
          d = src_data[i*WIDTH +: WIDTH];
          s = 3'(i);
        end else begin
          pend = 1;
        end
        return;
      end
    end
  endfunction

  function automatic logic model_ready();
    if (rst || flush || m_wait) return 1'b0;
    if (m_full) return out_ready;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit pend;
    logic [31:0] d;
    logic [2:0] s;
    if (rst) begin
      m_full = 0; m_wait = 0; m_data = 0; m_src = 3'd4; m_stall = 0;
    end else if (flush) begin
      m_full = 0; m_wait = 0;
    end else if (m_wait) begin
      if (m_stall < 16'hFFFF) m_stall++;
      ref_resolve(l_cmd, l_tag, l_dflt, pend, d, s);
      if (!pend) begin
        m_wait = 0; m_full = 1; m_data = d; m_src = s;
      end
    end else if (!m_full || out_ready) begin
      if (in_valid) begin
        ref_resolve(in_cmd, in_tag, in_default, pend, d, s);
        if (pend) begin
          m_wait = 1; m_full = 0; l_cmd = in_cmd; l_tag = in_tag; l_dflt = in_default;
        end else begin
          m_full = 1; m_data = d; m_src = s;
        end
      end else begin
        m_full = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    seen_rdy = in_ready;
    exp_rdy  = model_ready();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic b, input logic [4:0] t, input logic [31:0] d);
    src_valid[i] = v;
    src_busy[i]  = b;
    src_tag[i*TAGW +: TAGW]   = t;
    src_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; in_cmd = 0; in_tag = 0; in_default = 0;
    out_ready = 0; src_valid = 0; src_busy = 0; src_tag = 0; src_data = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; in_valid = 1; in_cmd = 2'd1; in_default = 32'h1111;
    cycle();
    total++; if (seen_rdy !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", seen_rdy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
    total++; if (out_src !== 3'd4) begin bad++; $display("FAIL reset_src got=%0d want=4", out_src); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_count); end
    idle();
  endtask

  task automatic test_forward_hit();
    idle();
    set_src(1, 1, 0, 5'd5, 32'hAAAA);
    set_src(3, 1, 0, 5'd5, 32'hBBBB);
    set_src(2, 0, 1, 5'd6, 32'h0);
    in_valid = 1; in_cmd = 2'd2; in_tag = 5'd5; in_default = 32'hDEAD;
    cycle();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hit_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 32'hAAAA) begin bad++; $display("FAIL hit_data got=%h want=aaaa", out_data); end
    total++; if (out_src !== 3'd1) begin bad++; $display("FAIL hit_src got=%0d want=1", out_src); end
    // Valid and busy together at the youngest index: the valid data is taken at once.
    out_ready = 1;
    set_src(0, 1, 1, 5'd5, 32'hC0DE);
    in_valid = 1;
    cycle();
    in_valid = 0;
    total++; if (out_data !== 32'hC0DE || out_src !== 3'd0) begin bad++; $display("FAIL hit_valid_busy got=%h/%0d want=c0de/0", out_data, out_src); end
    cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hit_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_pending();
    idle();
    do_reset();
    set_src(0, 0, 1, 5'd7, 32'h0);
    set_src(1, 1, 0, 5'd7, 32'h9999);
    in_valid = 1; in_cmd = 2'd2; in_tag = 5'd7; in_default = 32'h4444;
    cycle();
    in_valid = 0; in_default = 0;
    cycle();
    cycle();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL pend_wait got=%b/%b want=0/0", out_valid, in_ready); end
    set_src(0, 1, 0, 5'd7, 32'h1234);
    cycle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pend_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 32'h1234 || out_src !== 3'd0) begin bad++; $display("FAIL pend_data got=%h/%0d want=1234/0", out_data, out_src); end
    total++; if (stall_count !== 16'd3) begin bad++; $display("FAIL pend_stall got=%0d want=3", stall_count); end
    out_ready = 1;
    // Busy source disappears without data: latched default is used.
    set_src(0, 0, 1, 5'd7, 32'h0);
    set_src(1, 0, 0, 5'd7, 32'h0);
    in_valid = 1; in_default = 32'h5A5A;
    cycle();
    in_valid = 0; in_default = 0;
    set_src(0, 0, 0, 5'd7, 32'h0);
    cycle();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h5A5A || out_src !== 3'd4) begin bad++; $display("FAIL pend_dflt got=%b/%h/%0d want=1/5a5a/4", out_valid, out_data, out_src); end
    total++; if (stall_count !== 16'd4) begin bad++; $display("FAIL pend_stall2 got=%0d want=4", stall_count); end
    cycle();
  endtask

  task automatic test_backpressure();
    idle();
    in_valid = 1; in_cmd = 2'd1; in_default = 32'h55;
    cycle();
    out_ready = 0; in_default = 32'h66;
    for (int k = 0; k < 4; k++) begin
      cycle();
      total++; if (seen_rdy !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h55) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%b/%h want=0/1/55", k, seen_rdy, out_valid, out_data);
      end
    end
    out_ready = 1;
    cycle();
    total++; if (seen_rdy !== 1'b1 || out_data !== 32'h66 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_release got=%b/%h want=1/66", seen_rdy, out_data); end
    in_valid = 0;
    cycle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_zero_default();
    idle();
    out_ready = 1;
    set_src(0, 1, 0, 5'd0, 32'h99);
    set_src(2, 1, 0, 5'd3, 32'h77);
    in_valid = 1; in_cmd = 2'd2; in_tag = 5'd0; in_default = 32'h1234;
    cycle();
    total++; if (out_data !== 32'd0 || out_src !== 3'd4) begin bad++; $display("FAIL zd_tag0 got=%h/%0d want=0/4", out_data, out_src); end
    in_cmd = 2'd1; in_tag = 5'd3; in_default = 32'hCAFE;
    cycle();
    total++; if (out_data !== 32'hCAFE || out_src !== 3'd4) begin bad++; $display("FAIL zd_default got=%h/%0d want=cafe/4", out_data, out_src); end
    in_cmd = 2'd3; in_default = 32'hBEEF;
    cycle();
    total++; if (out_data !== 32'hBEEF || out_src !== 3'd4) begin bad++; $display("FAIL zd_cmd3 got=%h/%0d want=beef/4", out_data, out_src); end
    in_cmd = 2'd0; in_default = 32'hF00D;
    cycle();
    total++; if (out_data !== 32'd0 || out_src !== 3'd4) begin bad++; $display("FAIL zd_zero got=%h/%0d want=0/4", out_data, out_src); end
    in_cmd = 2'd2; in_tag = 5'd12; in_default = 32'h0BAD;
    cycle();
    total++; if (out_data !== 32'h0BAD || out_src !== 3'd4) begin bad++; $display("FAIL zd_miss got=%h/%0d want=bad/4", out_data, out_src); end
    in_valid = 0;
    cycle();
  endtask

  task automatic test_flush_reset();
    idle();
    do_reset();
    set_src(2, 0, 1, 5'd9, 32'h0);
    in_valid = 1; in_cmd = 2'd2; in_tag = 5'd9;
    cycle();
    in_valid = 0;
    cycle();
    cycle();
    total++; if (stall_count !== 16'd2 || out_valid !== 1'b0) begin bad++; $display("FAIL fl_wait got=%0d/%b want=2/0", stall_count, out_valid); end
    flush = 1; in_valid = 1; in_cmd = 2'd1; in_default = 32'h3;
    cycle();
    total++; if (seen_rdy !== 1'b0 || out_valid !== 1'b0 || stall_count !== 16'd2) begin bad++; $display("FAIL fl_flush got=%b/%b/%0d want=0/0/2", seen_rdy, out_valid, stall_count); end
    flush = 0; in_valid = 0;
    cycle();
    total++; if (out_valid !== 1'b0 || stall_count !== 16'd2) begin bad++; $display("FAIL fl_empty got=%b/%0d want=0/2", out_valid, stall_count); end
    in_valid = 1; in_cmd = 2'd1; in_default = 32'h77;
    cycle();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin bad++; $display("FAIL fl_full got=%b/%h want=1/77", out_valid, out_data); end
    rst = 1; flush = 1;
    cycle();
    rst = 0; flush = 0;
    total++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_src !== 3'd4 || stall_count !== 16'd0) begin
      bad++; $display("FAIL fl_rst got=%b/%h/%0d/%0d want=0/0/4/0", out_valid, out_data, out_src, stall_count);
    end
  endtask

  task automatic test_random();
    idle();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_cmd    = 2'($urandom_range(0, 3));
      in_tag    = 5'($urandom_range(0, 3));
      in_default = $urandom;
      for (int i = 0; i < NSRC; i++)
        set_src(i, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 3)), $urandom);
      cycle();
      total++; if (seen_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, seen_rdy, exp_rdy); end
      total++; if (out_valid !== m_full) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, out_valid, m_full); end
      if (m_full) begin
        total++; if (out_data !== m_data || out_src !== m_src) begin bad++; $display("FAIL rnd_data c=%0d got=%h/%0d want=%h/%0d", c, out_data, out_src, m_data, m_src); end
      end
      total++; if (stall_count !== 16'(m_stall)) begin bad++; $display("FAIL rnd_stall c=%0d got=%0d want=%0d", c, stall_count, m_stall); end
    end
    idle();
  endtask

  task automatic test_saturation();
    idle();
    do_reset();
    set_src(0, 0, 1, 5'd7, 32'h0);
    in_valid = 1; in_cmd = 2'd2; in_tag = 5'd7;
    cycle();
    in_valid = 0;
    for (int k = 0; k < 70000; k++) cycle();
    total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_max got=%h want=ffff", stall_count); end
    for (int k = 0; k < 5; k++) cycle();
    total++; if (stall_count !== 16'hFFFF || out_valid !== 1'b0) begin bad++; $display("FAIL sat_hold got=%h/%b want=ffff/0", stall_count, out_valid); end
    set_src(0, 1, 0, 5'd7, 32'hFACE);
    cycle();
    total++; if (out_valid !== 1'b1 || out_data !== 32'hFACE || stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_end got=%b/%h/%h want=1/face/ffff", out_valid, out_data, stall_count); end
    do_reset();
  endtask

  initial begin
    m_full = 0; m_wait = 0; m_data = 0; m_src = 3'd4; m_stall = 0;
    l_cmd = 0; l_tag = 0; l_dflt = 0;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_forward_hit();
    test_pending();
    test_backpressure();
    test_zero_default();
    test_flush_reset();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
